// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: defaults, NOP encoding and FSM states.
package fetch_stage_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load or insert a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // A bubble keeps pc/pc_plus4 so downstream debug still sees the last real PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= RV_NOP;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= RV_NOP;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_instr    <= i_instr;
        r_pc       <= i_pc;
        r_pc_plus4 <= i_pc_plus4;
        r_valid    <= 1'b1;
      end else begin
        r_instr <= RV_NOP;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, imem handshake FSM, stall hold buffer and redirect latch.
// Defining IF_PERF_CNT_EN adds saturating fetch/wait performance counters.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// RUN   | request at pc_f, response expected this cycle
// WAIT  | request outstanding, address held
// DRAIN | redirect arrived while waiting; finish and drop the old request
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    imem,
  input  logic             i_stall_f,
  input  logic             i_flush_d,
  input  logic             i_pc_src_e,
  input  logic [XLEN-1:0]  i_pc_target_e,
  output logic [31:0]      o_instr_d,
  output logic [XLEN-1:0]  o_pc_d,
  output logic [XLEN-1:0]  o_pc_plus4_d,
  output logic             o_valid_d
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      o_fetch_cnt,
  output logic [31:0]      o_wait_cnt
`endif
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc_f, w_pc_nxt;
  logic            r_hold_v, w_hold_v_nxt;
  logic [31:0]     r_hold_instr, w_hold_instr_nxt;
  logic [XLEN-1:0] r_redir_q, w_redir_nxt;

  logic            w_req;
  logic            w_fire;
  logic            w_load;
  logic [31:0]     w_load_instr;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;

  // No new request while a stalled response sits in the hold buffer.
  assign w_req      = (r_state != ST_BOOT) && !r_hold_v;
  assign w_fire     = w_req && imem.imem_ready;
  assign w_target   = {i_pc_target_e[XLEN-1:2], 2'b00};
  assign w_pc_plus4 = r_pc_f + XLEN'(4);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc_f       <= RESET_PC;
      r_hold_v     <= 1'b0;
      r_hold_instr <= RV_NOP;
      r_redir_q    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc_f       <= w_pc_nxt;
      r_hold_v     <= w_hold_v_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_redir_q    <= w_redir_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc_f;
    w_hold_v_nxt     = r_hold_v;
    w_hold_instr_nxt = r_hold_instr;
    w_redir_nxt      = r_redir_q;
    w_load           = 1'b0;
    w_load_instr     = imem.imem_rdata;
    unique case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        if (i_pc_src_e) w_pc_nxt = w_target;
      end
      ST_RUN, ST_WAIT: begin
        if (i_pc_src_e) begin
          w_hold_v_nxt = 1'b0;
          // An unanswered request must keep its address, so park the target.
          if ((r_state == ST_WAIT) && !w_fire) begin
            w_state_nxt = ST_DRAIN;
            w_redir_nxt = w_target;
          end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = w_target;
          end
        end else if (r_hold_v) begin
          if (i_flush_d) begin
            w_hold_v_nxt = 1'b0;
          end else if (!i_stall_f) begin
            w_load       = 1'b1;
            w_load_instr = r_hold_instr;
            w_pc_nxt     = w_pc_plus4;
            w_hold_v_nxt = 1'b0;
          end
        end else if (w_fire) begin
          w_state_nxt = ST_RUN;
          if (!i_stall_f) begin
            w_load   = 1'b1;
            w_pc_nxt = w_pc_plus4;
          end else if (!i_flush_d) begin
            w_hold_v_nxt     = 1'b1;
            w_hold_instr_nxt = imem.imem_rdata;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (w_fire) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = i_pc_src_e ? w_target : r_redir_q;
        end else if (i_pc_src_e) begin
          w_redir_nxt = w_target;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (i_stall_f),
    .i_flush   (i_flush_d),
    .i_load    (w_load),
    .i_instr   (w_load_instr),
    .i_pc      (r_pc_f),
    .i_pc_plus4(w_pc_plus4),
    .o_instr   (o_instr_d),
    .o_pc      (o_pc_d),
    .o_pc_plus4(o_pc_plus4_d),
    .o_valid   (o_valid_d)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_load && !i_flush_d && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && (r_wait_cnt != 32'hFFFF_FFFF))
        r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, wait states, stall hold, redirects, flush+stall, PC wrap.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pcsrc = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] tgt   = 32'h0;

  logic [31:0] instr_d, pc_d, pc4_d;
  logic        valid_d;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  fetch_stage_if #(.XLEN(32)) bus ();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .i_stall_f    (stall),
    .i_flush_d    (flush),
    .i_pc_src_e   (pcsrc),
    .i_pc_target_e(tgt),
    .o_instr_d    (instr_d),
    .o_pc_d       (pc_d),
    .o_pc_plus4_d (pc4_d),
    .o_valid_d    (valid_d)
`ifdef IF_PERF_CNT_EN
    ,
    .o_fetch_cnt  (fetch_cnt),
    .o_wait_cnt   (wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                          input logic [31:0] ep4, input logic ev);
    chk({tag, "_instr"}, instr_d, ei);
    chk({tag, "_pc"}, pc_d, ep);
    chk({tag, "_pc4"}, pc4_d, ep4);
    chk({tag, "_valid"}, {31'b0, valid_d}, {31'b0, ev});
  endtask

  task automatic chk_bus(input string tag, input logic er, input logic [31:0] ea);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, {31'b0, er});
    chk({tag, "_addr"}, bus.imem_addr, ea);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state; this is also the single BOOT cycle once rst drops
    cyc; cyc;
    chk_bus("rst", 1'b0, 32'h0);
    chk_ifid("rst", RV_NOP, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    cyc;
    chk_bus("run0", 1'b1, 32'h0);
    chk("boot_valid", {31'b0, valid_d}, 32'h0);
    cyc;
    chk_ifid("f0", mem_word(32'h0), 32'h0, 32'h4, 1'b1);
    chk_bus("f0", 1'b1, 32'h4);
    cyc;
    chk_ifid("f4", mem_word(32'h4), 32'h4, 32'h8, 1'b1);
    chk_bus("f4", 1'b1, 32'h8);

    // three wait cycles at 0x8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk_bus("wait8", 1'b1, 32'h8);
      chk_ifid("wait8", RV_NOP, 32'h4, 32'h8, 1'b0);
    end
    ready = 1'b1;
    cyc;
    chk_ifid("f8", mem_word(32'h8), 32'h8, 32'hC, 1'b1);
    chk_bus("f8", 1'b1, 32'hC);

    // two-cycle stall with ready: response for 0xC held, no new request
    stall = 1'b1;
    cyc;
    chk_bus("stall1", 1'b0, 32'hC);
    chk_ifid("stall1", mem_word(32'h8), 32'h8, 32'hC, 1'b1);
    cyc;
    chk_bus("stall2", 1'b0, 32'hC);
    chk_ifid("stall2", mem_word(32'h8), 32'h8, 32'hC, 1'b1);
    stall = 1'b0;
    cyc;
    chk_ifid("fC", mem_word(32'hC), 32'hC, 32'h10, 1'b1);
    chk_bus("fC", 1'b1, 32'h10);

    // redirect to 0x100 while waiting at 0x10 -> DRAIN
    ready = 1'b0;
    cyc;
    chk_bus("w10", 1'b1, 32'h10);
    chk("w10_valid", {31'b0, valid_d}, 32'h0);
    pcsrc = 1'b1; tgt = 32'h100;
    cyc;
    pcsrc = 1'b0;
    chk_bus("drain1", 1'b1, 32'h10);
    chk("drain1_valid", {31'b0, valid_d}, 32'h0);
    cyc;
    chk_bus("drain2", 1'b1, 32'h10);
    ready = 1'b1;
    cyc;
    chk_bus("redir100", 1'b1, 32'h100);
    chk_ifid("drop10", RV_NOP, 32'hC, 32'h10, 1'b0);
    cyc;
    chk_ifid("f100", mem_word(32'h100), 32'h100, 32'h104, 1'b1);
    chk_bus("f100", 1'b1, 32'h104);

    // redirect in RUN, misaligned target forced to 0x40
    pcsrc = 1'b1; tgt = 32'h43;
    cyc;
    pcsrc = 1'b0;
    chk_bus("redir40", 1'b1, 32'h40);
    chk("drop104_valid", {31'b0, valid_d}, 32'h0);
    cyc;
    chk_ifid("f40", mem_word(32'h40), 32'h40, 32'h44, 1'b1);
    chk_bus("f40", 1'b1, 32'h44);

    // flush and stall together -> bubble, 0x44 refetched
    flush = 1'b1; stall = 1'b1;
    cyc;
    flush = 1'b0; stall = 1'b0;
    chk_ifid("flstall", RV_NOP, 32'h40, 32'h44, 1'b0);
    chk_bus("flstall", 1'b1, 32'h44);
    cyc;
    chk_ifid("f44", mem_word(32'h44), 32'h44, 32'h48, 1'b1);

    // PC wrap at top of address space
    pcsrc = 1'b1; tgt = 32'hFFFF_FFFC;
    cyc;
    pcsrc = 1'b0;
    chk_bus("redirtop", 1'b1, 32'hFFFF_FFFC);
    cyc;
    chk_ifid("ftop", mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk_bus("wrap", 1'b1, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd8);
    chk("wait_cnt", wait_cnt, 32'd6);
`endif

    // reset while waiting discards the outstanding request
    ready = 1'b0;
    cyc;
    chk_bus("w0", 1'b1, 32'h0);
    rst = 1'b1;
    cyc;
    rst = 1'b0; ready = 1'b1;
    chk_bus("rst2", 1'b0, 32'h0);
    chk_ifid("rst2", RV_NOP, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("rst2_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst2_wait_cnt", wait_cnt, 32'd0);
`endif
    cyc;
    chk_bus("rst2_run", 1'b1, 32'h0);
    cyc;
    chk_ifid("rst2_f0", mem_word(32'h0), 32'h0, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
